// File: rtl/change_dispenser_if.sv
// Controller and ejector signals for change_dispenser. Inventory signals exist
// only when CHANGE_INVENTORY_EN is defined.
interface change_dispenser_if #(
  parameter int BAL_W = 7
`ifdef CHANGE_INVENTORY_EN
  , parameter int TUBE_W = 4
`endif
);
  logic             start;
  logic [BAL_W-1:0] amount;
  logic             eject_dime;
  logic             eject_nickel;
  logic             eject_ack;
  logic             busy;
  logic             done;
  logic [BAL_W-1:0] remaining;
`ifdef CHANGE_INVENTORY_EN
  logic              short;
  logic              refill_dime;
  logic              refill_nickel;
  logic [TUBE_W-1:0] dime_count;
  logic [TUBE_W-1:0] nickel_count;

  modport master (
    output start, amount, eject_ack, refill_dime, refill_nickel,
    input  eject_dime, eject_nickel, busy, done, remaining, short,
           dime_count, nickel_count
  );
  modport slave (
    input  start, amount, eject_ack, refill_dime, refill_nickel,
    output eject_dime, eject_nickel, busy, done, remaining, short,
           dime_count, nickel_count
  );
`else
  modport master (
    output start, amount, eject_ack,
    input  eject_dime, eject_nickel, busy, done, remaining
  );
  modport slave (
    input  start, amount, eject_ack,
    output eject_dime, eject_nickel, busy, done, remaining
  );
`endif
endinterface

// File: rtl/change_dispenser.sv
// Pays out a cent amount as dimes then nickels, one coin per ejector handshake.
// Define CHANGE_INVENTORY_EN to add per-tube coin inventories and the short flag.
module change_dispenser #(
  parameter int BAL_W = 7
`ifdef CHANGE_INVENTORY_EN
  , parameter int TUBE_W    = 4
  , parameter int TUBE_INIT = 8
`endif
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT_D, EJECT_N, DONE} state_t;

  localparam logic [BAL_W-1:0] DIME   = BAL_W'(10);
  localparam logic [BAL_W-1:0] NICKEL = BAL_W'(5);

  state_t           state, state_nx;
  logic [BAL_W-1:0] remaining_q;
  logic             dime_avail, nickel_avail;
  logic             dime_ack, nickel_ack;

  assign dime_ack   = (state == EJECT_D) && bus.eject_ack;
  assign nickel_ack = (state == EJECT_N) && bus.eject_ack;

  always_comb begin
    // NOTE: state_nx takes its default before the case, so every path assigns it and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SELECT;
      SELECT: begin
        if (remaining_q >= DIME && dime_avail)          state_nx = EJECT_D;
        else if (remaining_q >= NICKEL && nickel_avail) state_nx = EJECT_N;
        else                                            state_nx = DONE;
      end
      EJECT_D: if (bus.eject_ack) state_nx = SELECT;
      EJECT_N: if (bus.eject_ack) state_nx = SELECT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Subtraction only follows a >= check in SELECT, so remaining cannot wrap.
  always_ff @(posedge clk) begin
    if (reset)                            remaining_q <= '0;
    else if (state == IDLE && bus.start)  remaining_q <= bus.amount;
    else if (dime_ack)                    remaining_q <= remaining_q - DIME;
    else if (nickel_ack)                  remaining_q <= remaining_q - NICKEL;
  end

  assign bus.eject_dime   = (state == EJECT_D);
  assign bus.eject_nickel = (state == EJECT_N);
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.remaining    = remaining_q;

`ifdef CHANGE_INVENTORY_EN
  logic [TUBE_W-1:0] dime_q, nickel_q;
  logic              short_q;

  // A refill and a payout of the same tube in one cycle cancel out.
  function automatic logic [TUBE_W-1:0] tube_next(input logic [TUBE_W-1:0] cnt,
                                                  input logic refill,
                                                  input logic take);
    tube_next = cnt;
    if (refill && !take && cnt != '1) tube_next = cnt + TUBE_W'(1);
    else if (take && !refill)         tube_next = cnt - TUBE_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      dime_q   <= TUBE_W'(TUBE_INIT);
      nickel_q <= TUBE_W'(TUBE_INIT);
      short_q  <= 1'b0;
    end else begin
      dime_q   <= tube_next(dime_q, bus.refill_dime, dime_ack);
      nickel_q <= tube_next(nickel_q, bus.refill_nickel, nickel_ack);
      if (state == IDLE && bus.start)              short_q <= 1'b0;
      else if (state == SELECT && state_nx == DONE) short_q <= (remaining_q >= NICKEL);
    end
  end

  assign dime_avail       = (dime_q != '0);
  assign nickel_avail     = (nickel_q != '0);
  assign bus.short        = short_q;
  assign bus.dime_count   = dime_q;
  assign bus.nickel_count = nickel_q;
`else
  assign dime_avail   = 1'b1;
  assign nickel_avail = 1'b1;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a greedy coin model predicts the coin
// sequence, leftover and done cycle; a small ejector model answers requests.
module tb_change_dispenser;
  localparam int BAL_W = 7;
`ifdef CHANGE_INVENTORY_EN
  localparam int TUBE_W    = 4;
  localparam int TUBE_INIT = 8;
  localparam int TUBE_MAX  = 15;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_dimes, m_nickels;

  change_dispenser_if #(
    .BAL_W(BAL_W)
`ifdef CHANGE_INVENTORY_EN
    , .TUBE_W(TUBE_W)
`endif
  ) bus ();

  change_dispenser #(
    .BAL_W(BAL_W)
`ifdef CHANGE_INVENTORY_EN
    , .TUBE_W(TUBE_W)
    , .TUBE_INIT(TUBE_INIT)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.eject_ack = 1'b0;
`ifdef CHANGE_INVENTORY_EN
    bus.refill_dime   = 1'b0;
    bus.refill_nickel = 1'b0;
`endif
  endtask

  task automatic check_counts(input string tag);
`ifdef CHANGE_INVENTORY_EN
    check({tag, "_dime_count"}, bus.dime_count, m_dimes);
    check({tag, "_nickel_count"}, bus.nickel_count, m_nickels);
`endif
  endtask

  task automatic model_reset();
`ifdef CHANGE_INVENTORY_EN
    m_dimes   = TUBE_INIT;
    m_nickels = TUBE_INIT;
`else
    m_dimes   = 1000;
    m_nickels = 1000;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_eject_dime"}, bus.eject_dime, 0);
    check({tag, "_eject_nickel"}, bus.eject_nickel, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_remaining"}, bus.remaining, 0);
`ifdef CHANGE_INVENTORY_EN
    check({tag, "_short"}, bus.short, 0);
`endif
    check_counts(tag);
  endtask

  // One payout. dly<0 picks a random ack delay per coin; refill_mode 0/1/2 =
  // never/sometimes/always pulse a refill of the same tube with the ack.
  task automatic payout(input int amt, input int dly, input bit noisy, input int refill_mode);
    int  delay[32];
    bit  refill[32];
    int  coins[$];
    int  rem, nd, nn, wait_total, exp_cycle, k, w;
    bit  prev_req, busy_ok, got_done;
    rem = amt; nd = m_dimes; nn = m_nickels; wait_total = 0;
    for (int i = 0; i < 32; i++) begin
      delay[i]  = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      refill[i] = (refill_mode == 2) || (refill_mode == 1 && $urandom_range(0, 2) == 0);
    end
    while (coins.size() < 32) begin
      if (rem >= 10 && nd > 0) begin
        coins.push_back(10); rem -= 10;
        if (!refill[coins.size()-1]) nd--;
      end else if (rem >= 5 && nn > 0) begin
        coins.push_back(5); rem -= 5;
        if (!refill[coins.size()-1]) nn--;
      end else break;
    end
    for (int i = 0; i < coins.size(); i++) wait_total += delay[i];
    exp_cycle = 2 * coins.size() + 2 + wait_total;

    @(negedge clk);
    bus.amount = BAL_W'(amt);
    bus.start  = 1'b1;
    k = 0; w = 0; prev_req = 0; busy_ok = 1; got_done = 0;
    for (int cyc = 1; cyc <= exp_cycle + 8; cyc++) begin
      @(negedge clk);
      clear_inputs();
      if (noisy) bus.amount = BAL_W'($urandom);
`ifdef CHANGE_INVENTORY_EN
      if (cyc == 1) check("short_cleared", bus.short, 0);
`endif
      if (bus.done) begin
        check("done_cycle", cyc, exp_cycle);
        check("coins_paid", k, coins.size());
        check("remaining", bus.remaining, rem);
`ifdef CHANGE_INVENTORY_EN
        check("short", bus.short, rem >= 5);
`endif
        m_dimes = nd; m_nickels = nn;
        check_counts("done");
        got_done = 1;
        break;
      end
      if (!bus.busy) busy_ok = 0;
      if (bus.eject_dime || bus.eject_nickel) begin
        if (!prev_req) begin
          check("one_hot", bus.eject_dime & bus.eject_nickel, 0);
          if (k < coins.size()) check("coin", bus.eject_dime ? 10 : 5, coins[k]);
          else check("extra_coin", k + 1, coins.size());
          w = 0;
        end
        prev_req = 1;
        if (w >= delay[k & 31]) begin
          bus.eject_ack = 1'b1;
`ifdef CHANGE_INVENTORY_EN
          if (refill[k & 31]) begin
            if (bus.eject_dime) bus.refill_dime = 1'b1;
            else                bus.refill_nickel = 1'b1;
          end
`endif
          k++;
        end else w++;
      end else begin
        prev_req = 0;
        if (noisy) bus.eject_ack = 1'($urandom_range(0, 1));
      end
      if (noisy && $urandom_range(0, 3) == 0) bus.start = 1'b1;
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("busy_during", busy_ok, 1);
    @(negedge clk);
    clear_inputs();
    check("idle_after", bus.busy, 0);
    check("remaining_hold", bus.remaining, rem);
  endtask

  task automatic reset_mid();
    int guard;
    @(negedge clk);
    bus.amount = BAL_W'(50);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.eject_dime && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reached", bus.eject_dime, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_state("rst_mid");
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic refill_burst(input int nd, input int nn);
    for (int i = 0; i < ((nd > nn) ? nd : nn); i++) begin
      @(negedge clk);
      bus.refill_dime   = (i < nd);
      bus.refill_nickel = (i < nn);
    end
    @(negedge clk);
    clear_inputs();
    m_dimes   = (m_dimes + nd > TUBE_MAX) ? TUBE_MAX : m_dimes + nd;
    m_nickels = (m_nickels + nn > TUBE_MAX) ? TUBE_MAX : m_nickels + nn;
    check_counts("refill");
  endtask
`endif

  initial begin
    clear_inputs();
    bus.amount = '0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    reset_mid();
    payout(15, 0, 0, 0);
    payout(25, 3, 0, 0);
    payout(7, -1, 0, 0);
    payout(3, 0, 0, 0);
    payout(0, 0, 0, 0);
    payout(127, -1, 1, 0);

`ifdef CHANGE_INVENTORY_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    payout(80, 0, 0, 0);
    payout(20, 0, 0, 0);
    payout(15, 0, 0, 0);
    payout(15, -1, 0, 0);
    refill_burst(3, 20);
    payout(10, 1, 0, 2);
`endif

    repeat (40) begin
`ifdef CHANGE_INVENTORY_EN
      if ($urandom_range(0, 1) == 1)
        refill_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
`endif
      payout(int'($urandom_range(0, 127)), -1, 1'($urandom_range(0, 1)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
